// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side bundle of the shared-memory arbiter.
// The lock vector exists only when MEM_RR_ARB_LOCK_EN is defined.
interface mem_rr_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int DW    = 8,
    parameter int AW    = 5
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    req_we;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
`ifdef MEM_RR_ARB_LOCK_EN
    logic [N_REQ-1:0]    lock;
`endif
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic [DW-1:0]       rdata;
    logic                err;
    logic                busy;

`ifdef MEM_RR_ARB_LOCK_EN
    modport master (
        output req, req_we, req_addr, req_wdata, lock,
        input  gnt, done, rdata, err, busy
    );
    modport slave (
        input  req, req_we, req_addr, req_wdata, lock,
        output gnt, done, rdata, err, busy
    );
`else
    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, done, rdata, err, busy
    );
    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, done, rdata, err, busy
    );
`endif
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sequencer owning one single-port word memory.
// Define MEM_RR_ARB_LOCK_EN to let an owner chain accesses via lock.
module mem_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 17,
    parameter int AW    = 5
) (
    input logic             clk,
    input logic             rst_n,
    mem_rr_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [IW:0] NREQ_W  = (IW+1)'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_rd;
    logic          in_range;
    logic          mem_wr;
    logic          load;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IW:0]        sum;
    logic [IW-1:0]      win;
    logic               win_vld;
    logic [IW-1:0]      ptr_nxt;

    // Rotate req so ptr lands at bit 0; the lowest set bit is the winner.
    always_comb begin
        req_dbl = {bus.req, bus.req} >> ptr_q;
        req_rot = req_dbl[N_REQ-1:0];
        win_vld = |req_rot;
        sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) sum = (IW+1)'(k);
        end
        sum = sum + {1'b0, ptr_q};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        win = sum[IW-1:0];
    end

    assign ptr_nxt  = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
    assign in_range = {1'b0, addr_q} < DEPTH_W;
    assign mem_rd   = in_range ? mem[addr_q] : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_wr  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    load    = 1'b1;
                    owner_d = win;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_wr  = we_q && in_range;
                rdata_d = (!we_q && in_range) ? mem_rd : '0;
                err_d   = !in_range;
                state_d = S_RESP;
            end
            S_RESP: begin
                err_d = 1'b0;
`ifdef MEM_RR_ARB_LOCK_EN
                if (bus.lock[owner_q] && bus.req[owner_q]) begin
                    load    = 1'b1;
                    state_d = S_ACCESS;
                end else begin
                    ptr_d   = ptr_nxt;
                    state_d = S_IDLE;
                end
`else
                ptr_d   = ptr_nxt;
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            we_d    = bus.req_we[owner_d];
            addr_d  = bus.req_addr[owner_d*AW +: AW];
            wdata_d = bus.req_wdata[owner_d*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[addr_q] <= wdata_q;
    end

    assign bus.gnt   = (state_q == S_ACCESS) ? (N_REQ'(1) << owner_q) : '0;
    assign bus.done  = (state_q == S_RESP) ? (N_REQ'(1) << owner_q) : '0;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scoreboard bench with a transaction-level model
// of the round-robin memory arbiter.
module tb_mem_rr_arbiter;
    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 17;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.N_REQ(N), .DW(DW), .AW(AW)) bus ();

    mem_rr_arbiter #(
        .N_REQ(N), .DW(DW), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

`ifdef MEM_RR_ARB_LOCK_EN
    initial bus.lock = '0;
`endif

    typedef struct {
        int          owner;
        int          cap;
        bit          we;
        int          addr;
        logic [DW-1:0] old;
        bit          oldk;
        logic [DW-1:0] rdata;
        bit          err;
        bit          chk;
    } exp_t;

    typedef struct {
        bit          we;
        int          addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    exp_t          sb[$];
    cmd_t          cmdq[N][$];
    logic [DW-1:0] mmem[DEPTH];
    bit            known[DEPTH];

    int checks = 0;
    int failures = 0;
    int edges = 0;
    int ptr = 0;
    int free_at = 0;
    int timeouts = 0;
    int to_seen = 0;
    bit rand_en = 1'b0;
    bit rst_on_gnt1 = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard head.
    exp_t          m_it;
    bit            m_has;
    logic [N-1:0]  m_gexp;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            chk("rst_gnt", 32'(bus.gnt), 0);
            chk("rst_done", 32'(bus.done), 0);
            chk("rst_rdata", 32'(bus.rdata), 0);
            chk("rst_err", 32'(bus.err), 0);
            chk("rst_busy", 32'(bus.busy), 0);
        end else begin
            m_has = sb.size() != 0;
            if (m_has) m_it = sb[0];
            m_gexp = (m_has && edges == m_it.cap) ? (N'(1) << m_it.owner) : '0;
            chk("gnt", 32'(bus.gnt), 32'(m_gexp));
            chk("busy", 32'(bus.busy), 32'(m_has && edges >= m_it.cap));
            if (bus.done != 0 || (m_has && edges >= m_it.cap + 1)) begin
                if (!m_has) begin
                    chk("done_unexpected", 32'(bus.done), 0);
                end else begin
                    void'(sb.pop_front());
                    chk("done", 32'(bus.done), 32'(N'(1) << m_it.owner));
                    chk("done_time", edges, m_it.cap + 1);
                    chk("err", 32'(bus.err), 32'(m_it.err));
                    if (m_it.chk) chk("rdata", 32'(bus.rdata), 32'(m_it.rdata));
                end
            end
        end
        if (timeouts != to_seen) begin
            to_seen = timeouts;
            checks++;
            failures++;
            $display("FAIL timeout: got %0d expired waits expected 0", timeouts);
        end
    end

    task automatic issue(int i, cmd_t c);
        bus.req[i]                 = 1'b1;
        bus.req_we[i]              = c.we;
        bus.req_addr[i*AW +: AW]   = AW'(c.addr);
        bus.req_wdata[i*DW +: DW]  = c.wdata;
    endtask

    task automatic push_cmd(int i, bit we, int addr, logic [DW-1:0] d);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        c.wdata = d;
        cmdq[i].push_back(c);
    endtask

    // Reference model: one access per 3 cycles, winner by rotating priority.
    task automatic model_step();
        exp_t          it;
        int            e;
        int            w;
        int            idx;
        logic [DW-1:0] wd;
        e = edges + 1;
        if (!rst_n || e < free_at || bus.req == 0) return;
        w = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (w < 0 && bus.req[idx]) w = idx;
        end
        it.owner = w;
        it.cap   = e;
        it.we    = bus.req_we[w];
        it.addr  = int'(bus.req_addr[w*AW +: AW]);
        wd       = bus.req_wdata[w*DW +: DW];
        it.err   = it.addr >= DEPTH;
        it.rdata = '0;
        it.old   = '0;
        it.oldk  = 1'b0;
        it.chk   = 1'b1;
        if (!it.err) begin
            if (it.we) begin
                it.old  = mmem[it.addr];
                it.oldk = known[it.addr];
                mmem[it.addr]  = wd;
                known[it.addr] = 1'b1;
            end else begin
                it.rdata = mmem[it.addr];
                it.chk   = known[it.addr];
            end
        end
        sb.push_back(it);
        ptr = (w + 1) % N;
        free_at = e + 3;
    endtask

    task automatic do_reset();
        exp_t it;
        rst_n = 1'b0;
        while (sb.size() != 0) begin
            it = sb.pop_back();
            if (it.we && !it.err) begin
                mmem[it.addr]  = it.old;
                known[it.addr] = it.oldk;
            end
        end
        ptr = 0;
        free_at = 0;
        bus.req = '0;
        rst_on_gnt1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_cycle();
        cmd_t c;
        @(negedge clk);
        if (rst_on_gnt1 && bus.gnt[1]) begin
            do_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.req[i] && bus.gnt[i]) bus.req[i] = 1'b0;
            if (!bus.req[i]) begin
                if (cmdq[i].size() != 0) begin
                    c = cmdq[i].pop_front();
                    issue(i, c);
                end else if (rand_en && $urandom_range(0, 3) != 0) begin
                    c.we    = 1'($urandom_range(0, 1));
                    c.addr  = $urandom_range(0, DEPTH + 2);
                    c.wdata = DW'($urandom);
                    issue(i, c);
                end
            end
        end
        model_step();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 300 && !(sb.size() == 0 && bus.req == 0 &&
               cmdq[0].size() == 0 && cmdq[1].size() == 0)) begin
            drive_cycle();
            t++;
        end
        if (t >= 300) timeouts++;
    endtask

    initial begin
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;

        repeat (4) begin
            @(negedge clk);
            bus.req       = N'($urandom);
            bus.req_we    = N'($urandom);
            bus.req_addr  = (N*AW)'($urandom);
            bus.req_wdata = (N*DW)'($urandom);
        end
        @(negedge clk);
        bus.req = '0;
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) push_cmd(0, 1'b1, a, DW'($urandom));
        wait_idle();

        push_cmd(0, 1'b1, 3, 8'h5A);
        push_cmd(0, 1'b0, 3, 8'h00);
        wait_idle();

        push_cmd(1, 1'b1, 17, 8'hFF);
        push_cmd(1, 1'b0, 16, 8'h00);
        push_cmd(1, 1'b0, 17, 8'h00);
        wait_idle();

        push_cmd(0, 1'b0, 0, 8'h00);
        push_cmd(0, 1'b0, 0, 8'h00);
        push_cmd(1, 1'b0, 1, 8'h00);
        push_cmd(1, 1'b0, 1, 8'h00);
        wait_idle();

        rand_en = 1'b1;
        repeat (400) drive_cycle();
        rand_en = 1'b0;
        wait_idle();

        push_cmd(1, 1'b1, 2, ~mmem[2]);
        rst_on_gnt1 = 1'b1;
        for (int t = 0; t < 50 && rst_on_gnt1; t++) drive_cycle();
        if (rst_on_gnt1) timeouts++;
        rst_on_gnt1 = 1'b0;
        push_cmd(0, 1'b0, 2, 8'h00);
        push_cmd(1, 1'b0, 2, 8'h00);
        wait_idle();

        repeat (3) @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
